mux_arb_nto1_reg: RTL

- Parametrised N-input, W-bit multiplexer with a registered output stage and a valid/ready handshake on every input and on the output.
- Two selection modes: explicit select, the direct successor of the fixed 4-to-1 5-bit select muxes, and round-robin arbitration.
- Used in the pipeline where several producers share one consumer, e.g. competing write-register-number/result sources ahead of register-file writeback or stall-capable stages.
- Defaults reproduce a 4-input, 5-bit mux with one cycle of latency.

---
 rtl/mux_arb_nto1_reg.sv | 116 +++++++++++
 1 files changed

// File: rtl/mux_arb_nto1_reg.sv
// N-input, W-bit multiplexer with a single registered output stage.
// Every input and the output use a valid/ready handshake. The channel is
// chosen either by an explicit select or by round-robin arbitration.
module mux_arb_nto1_reg #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 5,
    parameter int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_src,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] rr_next;
    logic [SW-1:0] grant_idx;
    logic          grant_hit;
    logic [W-1:0]  grant_data;
    logic          load_en;
    logic          xfer;

    // Per-channel candidates for round-robin: the first valid channel at or
    // above rr_ptr wins; if none exists, the first valid channel below it.
    logic [SW-1:0] hi_idx;
    logic [SW-1:0] lo_idx;
    logic          hi_hit;
    logic          lo_hit;

    // Grant decision for the current cycle.
    always_comb begin
        grant_idx = '0;
        grant_hit = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        hi_hit    = 1'b0;
        lo_hit    = 1'b0;
        if (N == 1) begin
            grant_hit = in_valid[0];
        end else if (!mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (in_valid[i] && (32'(sel) == i)) begin
                    grant_hit = 1'b1;
                    grant_idx = SW'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (in_valid[i]) begin
                    if (32'(rr_ptr) <= i) begin
                        if (!hi_hit) begin
                            hi_hit = 1'b1;
                            hi_idx = SW'(i);
                        end
                    end else if (!lo_hit) begin
                        lo_hit = 1'b1;
                        lo_idx = SW'(i);
                    end
                end
            end
            grant_hit = hi_hit | lo_hit;
            grant_idx = hi_hit ? hi_idx : lo_idx;
        end
    end

    // Data of the granted channel and the pointer that follows it.
    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == SW'(i)) begin
                grant_data = in_data[i*W +: W];
            end
        end
        rr_next = (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end

    assign load_en = !out_valid | out_ready;
    assign xfer    = load_en & grant_hit & !Reset;

    // Ready goes only to the granted channel, and only when the output can load.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (xfer && (grant_idx == SW'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_data  <= grant_data;
            out_src   <= grant_idx;
            out_valid <= 1'b1;
            if (mode) begin
                rr_ptr <= rr_next;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
